// File: rtl/la_pkg.sv
`default_nettype none
// ==== la_pkg : shared types for the logic-analyser capture path ==== Rev 1.0
package la_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    POSTTRIG = 3'd2,
    DONE     = 3'd3,
    READOUT  = 3'd4
  } cap_state_t;

  localparam int unsigned LA_ADDR_BITS = 10;

  function automatic logic state_is_busy(input cap_state_t s);
    return (s == ARMED) || (s == POSTTRIG) || (s == READOUT);
  endfunction
endpackage
`default_nettype wire

// File: rtl/capture_controller_if.sv
`default_nettype none
// ==== capture_controller_if : control, RAM-side and host-readout signals ==== Rev 1.0
interface capture_controller_if #(
  parameter int unsigned ADDR_BITS = la_pkg::LA_ADDR_BITS
) ();
  logic                 arm;
  logic                 abort;
  logic                 trigger;
  logic                 sample_valid;
  logic                 delay_match;
  logic                 read_match;
  logic                 cnt_en;
  logic                 cnt_clr;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [ADDR_BITS-1:0] mem_raddr;
  logic [ADDR_BITS-1:0] trig_addr;
  logic                 rd_start;
  logic                 rd_valid;
  logic                 rd_ready;
  logic                 rd_last;
  logic                 busy;
  logic                 done;

  // master = the capture controller, slave = its surroundings
  modport master (
    input  arm, abort, trigger, sample_valid, delay_match, read_match, rd_start, rd_ready,
    output cnt_en, cnt_clr, mem_we, mem_waddr, mem_raddr, trig_addr,
           rd_valid, rd_last, busy, done
  );

  modport slave (
    output arm, abort, trigger, sample_valid, delay_match, read_match, rd_start, rd_ready,
    input  cnt_en, cnt_clr, mem_we, mem_waddr, mem_raddr, trig_addr,
           rd_valid, rd_last, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/capture_controller.sv
`default_nettype none
// ==== capture_controller : arm/trigger/post-trigger capture into a circular RAM,
//      then valid/ready readout of the captured window ==== Rev 1.0
module capture_controller
  import la_pkg::*;
#(
  parameter int unsigned ADDR_BITS = LA_ADDR_BITS
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  capture_controller_if.master bus
);

  cap_state_t           r_state;
  cap_state_t           w_next;
  logic [ADDR_BITS-1:0] r_waddr;
  logic [ADDR_BITS-1:0] r_raddr;
  logic [ADDR_BITS-1:0] r_trig_addr;
  logic [ADDR_BITS-1:0] w_raddr_nxt;
  logic                 r_rd_valid;
  logic                 w_we;
  logic                 w_cnt_en;
  logic                 w_cnt_clr;
  logic                 w_rd_valid;
  logic                 w_rd_last;
  logic                 w_accept;

  always_comb begin
    w_next      = r_state;
    w_we        = 1'b0;
    w_cnt_en    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_rd_valid  = 1'b0;
    w_rd_last   = 1'b0;
    w_accept    = 1'b0;
    w_raddr_nxt = r_raddr;

    unique case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (bus.arm) w_next = ARMED;
      end
      ARMED: begin
        w_cnt_clr = 1'b1;
        w_we      = bus.sample_valid;
        if (bus.trigger && bus.sample_valid) w_next = POSTTRIG;
      end
      POSTTRIG: begin
        // The match cycle itself stores nothing, so delay N keeps exactly N samples
        if (bus.delay_match) begin
          w_next = DONE;
        end else begin
          w_we     = bus.sample_valid;
          w_cnt_en = bus.sample_valid;
        end
      end
      DONE: begin
        w_cnt_clr = 1'b1;
        if (bus.rd_start) w_next = READOUT;
      end
      READOUT: begin
        w_rd_valid  = r_rd_valid;
        w_accept    = r_rd_valid && bus.rd_ready;
        w_rd_last   = r_rd_valid && bus.read_match;
        w_cnt_en    = w_accept && !bus.read_match;
        // Look one address ahead on accept so the next word is ready without a bubble
        w_raddr_nxt = w_accept ? r_raddr + ADDR_BITS'(1) : r_raddr;
        if (w_accept && w_rd_last) w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase

    if (bus.abort) begin
      w_next   = IDLE;
      w_we     = 1'b0;
      w_cnt_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_waddr     <= '0;
      r_raddr     <= '0;
      r_trig_addr <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_we) r_waddr <= r_waddr + ADDR_BITS'(1);
      if (r_state == ARMED && w_next == POSTTRIG) r_trig_addr <= r_waddr;
      if (r_state == DONE && w_next == READOUT) begin
        r_raddr <= r_waddr;
      end else if (r_state == READOUT) begin
        r_raddr <= w_raddr_nxt;
      end
      // First readout cycle waits out the registered RAM read
      r_rd_valid <= (r_state == READOUT) && (w_next == READOUT);
    end
  end

  assign bus.cnt_en    = w_cnt_en;
  assign bus.cnt_clr   = w_cnt_clr;
  assign bus.mem_we    = w_we;
  assign bus.mem_waddr = r_waddr;
  assign bus.mem_raddr = (r_state == READOUT) ? w_raddr_nxt : r_raddr;
  assign bus.trig_addr = r_trig_addr;
  assign bus.rd_valid  = w_rd_valid;
  assign bus.rd_last   = w_rd_last;
  assign bus.busy      = state_is_busy(r_state);
  assign bus.done      = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_capture_controller.sv
`default_nettype none
// tb_capture_controller : scoreboard bench with a sample_counter model and a
// registered-read sample RAM model around the controller (ADDR_BITS = 4).
module tb_capture_controller;
  localparam int AB    = 4;
  localparam int DEPTH = 1 << AB;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  capture_controller_if #(.ADDR_BITS(AB)) ifc ();
  capture_controller #(.ADDR_BITS(AB)) dut (.clk(clk), .reset_n(reset_n), .bus(ifc));

  logic [7:0] sdata;
  logic [7:0] rd_data;
  logic [7:0] ram [DEPTH];
  logic [7:0] cnt;
  logic [7:0] delay_reg;
  logic [7:0] read_reg;

  always @(posedge clk) begin
    if (!reset_n || ifc.cnt_clr) cnt <= '0;
    else if (ifc.cnt_en)         cnt <= cnt + 8'd1;
    if (ifc.mem_we) ram[ifc.mem_waddr] <= sdata;
    rd_data <= ram[ifc.mem_raddr];
  end
  assign ifc.delay_match = (cnt == delay_reg);
  assign ifc.read_match  = (cnt == read_reg);

  int            total     = 0;
  int            bad       = 0;
  int            strobe_no = 1;
  logic [AB-1:0] exp_waddr;
  logic [7:0]    exp_mem [DEPTH];
  logic [AB-1:0] wq[$];
  logic [7:0]    rq[$];

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.arm = 1'b0; ifc.abort = 1'b0; ifc.trigger = 1'b0;
    ifc.sample_valid = 1'b0; ifc.rd_start = 1'b0; ifc.rd_ready = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset_n = 1'b0;
    next_cyc();
    next_cyc();
    reset_n = 1'b1;
    exp_waddr = '0;
  endtask

  task automatic reach_done(output bit ok);
    ok = 1'b0;
    clear_inputs();
    ifc.abort = 1'b1; next_cyc(); ifc.abort = 1'b0;
    delay_reg = 8'd0;
    ifc.arm = 1'b1; next_cyc(); ifc.arm = 1'b0;
    sdata = 8'(strobe_no); strobe_no++;
    ifc.sample_valid = 1'b1; ifc.trigger = 1'b1; next_cyc();
    ifc.sample_valid = 1'b0; ifc.trigger = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = (ifc.done === 1'b1);
      next_cyc();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    next_cyc();
    @(negedge clk);
    total++;
    if ({ifc.busy, ifc.done, ifc.mem_we, ifc.cnt_en, ifc.cnt_clr, ifc.rd_valid, ifc.rd_last} !== 7'b0000100) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000100",
               {ifc.busy, ifc.done, ifc.mem_we, ifc.cnt_en, ifc.cnt_clr, ifc.rd_valid, ifc.rd_last});
    end
    total++;
    if ({ifc.mem_waddr, ifc.mem_raddr, ifc.trig_addr} !== '0) begin
      bad++;
      $display("FAIL reset_addr: waddr=%0d raddr=%0d trig=%0d want 0 0 0", ifc.mem_waddr, ifc.mem_raddr, ifc.trig_addr);
    end
    next_cyc();
    reset_n = 1'b1;
    exp_waddr = '0;
  endtask

  task automatic test_capture(input int delay, input int pre, input string tag);
    logic [AB-1:0] exp_trig;
    int            post_writes;
    int            cen_cycles;
    bit            got_done;
    exp_trig = '0; post_writes = 0; cen_cycles = 0; got_done = 1'b0;
    wq.delete();
    delay_reg = 8'(delay);
    clear_inputs();
    ifc.abort = 1'b1; next_cyc(); ifc.abort = 1'b0;
    ifc.arm = 1'b1; next_cyc(); ifc.arm = 1'b0;
    @(negedge clk);
    total++;
    if (ifc.busy !== 1'b1) begin bad++; $display("FAIL %s_armed: busy=%b want 1", tag, ifc.busy); end
    next_cyc();
    // Each strobe is preceded by a lone trigger that must be ignored
    for (int k = 0; k <= pre; k++) begin
      ifc.trigger = 1'b1; ifc.sample_valid = 1'b0;
      @(negedge clk);
      total++;
      if (ifc.mem_we !== 1'b0) begin bad++; $display("FAIL %s_gap_we: got %b want 0", tag, ifc.mem_we); end
      next_cyc();
      sdata = 8'(strobe_no); strobe_no++;
      ifc.sample_valid = 1'b1; ifc.trigger = (k == pre);
      exp_mem[exp_waddr] = sdata;
      wq.push_back(exp_waddr);
      if (k == pre) exp_trig = exp_waddr;
      exp_waddr++;
      @(negedge clk);
      total++;
      if (ifc.mem_we !== 1'b1 || wq.size() == 0 || ifc.mem_waddr !== wq[0]) begin
        bad++;
        $display("FAIL %s_pre_write: we=%b addr=%0d want we=1 addr=%0d", tag, ifc.mem_we, ifc.mem_waddr, exp_waddr - AB'(1));
      end
      if (wq.size() != 0) void'(wq.pop_front());
      next_cyc();
    end
    for (int cyc = 0; cyc < 100; cyc++) begin
      ifc.trigger = 1'b0;
      ifc.sample_valid = (cyc % 2 == 0);
      if (ifc.sample_valid) begin
        sdata = 8'(strobe_no); strobe_no++;
        if (post_writes < delay) begin
          exp_mem[exp_waddr] = sdata;
          wq.push_back(exp_waddr);
          exp_waddr++;
          post_writes++;
        end
      end
      @(negedge clk);
      if (ifc.cnt_en === 1'b1) cen_cycles++;
      if (ifc.mem_we === 1'b1) begin
        total++;
        if (wq.size() == 0 || ifc.mem_waddr !== wq[0]) begin
          bad++;
          $display("FAIL %s_post_write: addr=%0d pending=%0d want a queued address", tag, ifc.mem_waddr, wq.size());
        end
        if (wq.size() != 0) void'(wq.pop_front());
      end
      if (ifc.done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      next_cyc();
    end
    next_cyc();
    clear_inputs();
    total++;
    if (!got_done) begin bad++; $display("FAIL %s_done: got timeout want done", tag); end
    total++;
    if (wq.size() != 0) begin bad++; $display("FAIL %s_missing: got %0d unwritten want 0", tag, wq.size()); end
    total++;
    if (ifc.trig_addr !== exp_trig) begin bad++; $display("FAIL %s_trig_addr: got %0d want %0d", tag, ifc.trig_addr, exp_trig); end
    total++;
    if (ifc.mem_waddr !== exp_waddr) begin bad++; $display("FAIL %s_waddr: got %0d want %0d", tag, ifc.mem_waddr, exp_waddr); end
    total++;
    if (cen_cycles != delay) begin bad++; $display("FAIL %s_cnt_en: got %0d cycles want %0d", tag, cen_cycles, delay); end
    total++;
    if ({ifc.busy, ifc.done} !== 2'b01) begin bad++; $display("FAIL %s_status: got %b want 01", tag, {ifc.busy, ifc.done}); end
  endtask

  task automatic test_readout(input int rr);
    int         beat;
    bit         prev_stall;
    bit         finished;
    logic [7:0] prev_data;
    logic       prev_last;
    beat = 0; prev_stall = 1'b0; finished = 1'b0; prev_data = '0; prev_last = 1'b0;
    read_reg = 8'(rr);
    rq.delete();
    for (int i = 0; i <= rr; i++) rq.push_back(exp_mem[exp_waddr + AB'(i)]);
    ifc.rd_start = 1'b1; ifc.rd_ready = 1'b1;
    next_cyc();
    ifc.rd_start = 1'b0;
    @(negedge clk);
    total++;
    if ({ifc.busy, ifc.rd_valid} !== 2'b10) begin bad++; $display("FAIL rd_first: busy,valid=%b want 10", {ifc.busy, ifc.rd_valid}); end
    for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
      next_cyc();
      ifc.rd_ready = (cyc % 2 == 0);
      @(negedge clk);
      if (prev_stall) begin
        total++;
        if ({ifc.rd_valid, rd_data, ifc.rd_last} !== {1'b1, prev_data, prev_last}) begin
          bad++;
          $display("FAIL rd_stall: valid=%b data=%h last=%b want 1 %h %b", ifc.rd_valid, rd_data, ifc.rd_last, prev_data, prev_last);
        end
      end
      prev_stall = ifc.rd_valid && !ifc.rd_ready;
      prev_data  = rd_data;
      prev_last  = ifc.rd_last;
      if (ifc.rd_valid && ifc.rd_ready) begin
        total++;
        if (rq.size() == 0 || {rd_data, ifc.rd_last} !== {rq[0], beat == rr}) begin
          bad++;
          $display("FAIL rd_beat%0d: data=%h last=%b want %h %b", beat, rd_data, ifc.rd_last,
                   (rq.size() != 0) ? rq[0] : 8'h00, beat == rr);
        end
        if (rq.size() != 0) void'(rq.pop_front());
        if (ifc.rd_last) finished = 1'b1;
        beat++;
      end
    end
    total++;
    if (beat != rr + 1) begin bad++; $display("FAIL rd_count: got %0d beats want %0d", beat, rr + 1); end
    next_cyc();
    ifc.rd_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({ifc.busy, ifc.done, ifc.rd_valid} !== 3'b000) begin
      bad++; $display("FAIL rd_end_idle: busy,done,valid=%b want 000", {ifc.busy, ifc.done, ifc.rd_valid});
    end
    next_cyc();
  endtask

  task automatic test_abort();
    bit ok;
    clear_inputs();
    ifc.abort = 1'b1; next_cyc(); ifc.abort = 1'b0;
    delay_reg = 8'd5;
    ifc.arm = 1'b1; next_cyc(); ifc.arm = 1'b0;
    ifc.sample_valid = 1'b1; ifc.trigger = 1'b1; next_cyc();
    ifc.trigger = 1'b0;
    next_cyc();
    next_cyc();
    ifc.abort = 1'b1;
    @(negedge clk);
    total++;
    if ({ifc.mem_we, ifc.cnt_en} !== 2'b00) begin bad++; $display("FAIL abort_post_we: we,en=%b want 00", {ifc.mem_we, ifc.cnt_en}); end
    next_cyc();
    ifc.abort = 1'b0;
    @(negedge clk);
    total++;
    if ({ifc.busy, ifc.done, ifc.mem_we, ifc.rd_valid, ifc.cnt_clr} !== 5'b00001) begin
      bad++; $display("FAIL abort_post_idle: got %b want 00001", {ifc.busy, ifc.done, ifc.mem_we, ifc.rd_valid, ifc.cnt_clr});
    end
    next_cyc();
    reach_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL abort_reach_done: got timeout want done"); end
    ifc.rd_start = 1'b1; next_cyc(); ifc.rd_start = 1'b0;
    next_cyc();
    @(negedge clk);
    total++;
    if ({ifc.busy, ifc.rd_valid} !== 2'b11) begin bad++; $display("FAIL abort_rd_pre: busy,valid=%b want 11", {ifc.busy, ifc.rd_valid}); end
    next_cyc();
    ifc.abort = 1'b1; next_cyc(); ifc.abort = 1'b0;
    @(negedge clk);
    total++;
    if ({ifc.busy, ifc.done, ifc.mem_we, ifc.rd_valid, ifc.cnt_clr} !== 5'b00001) begin
      bad++; $display("FAIL abort_rd_idle: got %b want 00001", {ifc.busy, ifc.done, ifc.mem_we, ifc.rd_valid, ifc.cnt_clr});
    end
    next_cyc();
  endtask

  task automatic test_reset_readout();
    bit ok;
    reach_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rst_reach_done: got timeout want done"); end
    ifc.rd_start = 1'b1; next_cyc(); ifc.rd_start = 1'b0;
    next_cyc();
    reset_n = 1'b0; ifc.rd_ready = 1'b1;
    next_cyc();
    @(negedge clk);
    total++;
    if ({ifc.busy, ifc.done, ifc.mem_we, ifc.cnt_en, ifc.cnt_clr, ifc.rd_valid, ifc.rd_last} !== 7'b0000100) begin
      bad++;
      $display("FAIL rst_rd_flags: got %b want 0000100",
               {ifc.busy, ifc.done, ifc.mem_we, ifc.cnt_en, ifc.cnt_clr, ifc.rd_valid, ifc.rd_last});
    end
    total++;
    if ({ifc.mem_waddr, ifc.mem_raddr, ifc.trig_addr} !== '0) begin
      bad++;
      $display("FAIL rst_rd_addr: waddr=%0d raddr=%0d trig=%0d want 0 0 0", ifc.mem_waddr, ifc.mem_raddr, ifc.trig_addr);
    end
    next_cyc();
    reset_n = 1'b1;
    exp_waddr = '0;
    ifc.rd_ready = 1'b0;
    reach_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rst_reach_done2: got timeout want done"); end
    ifc.arm = 1'b1; next_cyc(); ifc.arm = 1'b0;
    @(negedge clk);
    total++;
    if ({ifc.busy, ifc.done} !== 2'b01) begin bad++; $display("FAIL arm_in_done: busy,done=%b want 01", {ifc.busy, ifc.done}); end
    next_cyc();
    ifc.abort = 1'b1; next_cyc(); ifc.abort = 1'b0;
    ifc.arm = 1'b1; next_cyc();
    ifc.rd_start = 1'b1; ifc.rd_ready = 1'b1;
    next_cyc();
    ifc.rd_start = 1'b0; ifc.arm = 1'b0;
    next_cyc();
    @(negedge clk);
    total++;
    if ({ifc.busy, ifc.done, ifc.rd_valid} !== 3'b100) begin
      bad++; $display("FAIL start_in_armed: busy,done,valid=%b want 100", {ifc.busy, ifc.done, ifc.rd_valid});
    end
    next_cyc();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    sdata = '0; delay_reg = '0; read_reg = '0; exp_waddr = '0;
    test_reset();
    test_capture(4, 2, "d4");
    test_capture(0, 0, "d0");
    apply_reset();
    test_capture(2, 20, "wrap");
    test_readout(3);
    test_abort();
    test_reset_readout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
